nn_top: RTL and testbench

Fixed-function, fixed-point neural-network inference engine: a 6-input, 4-hidden-neuron (ReLU), 1-output fully-connected network with weights held in internal constant ROM. It sits at the top of the NN datapath, free-runs continuously after reset, and samples `data_in` at the start of each inference. It presents the most recent result on `data_out` with a sticky valid flag. All computation uses one shared sequential multiply-accumulate (MAC) unit.

---
 rtl/nn_top.sv | 165 ++++++++++++++++
 tb/tb_nn_top.sv | 126 ++++++++++++
 2 files changed

// File: rtl/nn_top.sv
// 6-4-1 fixed-point MLP (Q8.8, ReLU hidden) on one shared MAC; free-running 34-cycle inference loop.
// Latency 33 edges from LOAD to result; no backpressure, data_out holds the last result with a sticky valid.
module nn_top #(
    parameter int FRAC = 8
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [15:0]        data_in [6],
    output logic signed [15:0] data_out,
    output logic               data_out_v
);

    typedef enum logic [1:0] {S_LOAD, S_L1, S_L2} state_t;

    // All biases are zero, so every neuron starts from an empty accumulator.
    localparam logic signed [39:0] ACC_PRELOAD = '0;

    state_t             state_q, state_d;
    logic [1:0]         nrn_q, nrn_d;
    logic [2:0]         tap_q, tap_d;
    logic signed [39:0] acc_q, acc_d;
    logic signed [15:0] out_q, out_d;
    logic               vld_q, vld_d;
    logic signed [15:0] xbuf_q [6];
    logic signed [15:0] h_q [4];

    logic               load_en;
    logic               h_we;
    logic signed [15:0] mac_a, mac_b;
    logic signed [31:0] prod;
    logic signed [15:0] fin_val;

    function automatic logic signed [15:0] w1_rom(input logic [1:0] j, input logic [2:0] k);
        logic signed [15:0] w;
        w = '0;
        case (j)
            2'd0: if (k == 3'd0 || k == 3'd1) w = 16'sh0100;
            2'd1: if (k == 3'd2 || k == 3'd3) w = 16'sh0100;
            2'd2: if (k == 3'd4 || k == 3'd5) w = 16'sh0100;
            default: begin
                if (k == 3'd0)      w = 16'sh0100;
                else if (k == 3'd5) w = 16'shFF00;
            end
        endcase
        return w;
    endfunction

    function automatic logic signed [15:0] w2_rom(input logic [2:0] k);
        logic signed [15:0] w;
        w = '0;
        case (k)
            3'd0, 3'd1, 3'd2: w = 16'sh0080;
            3'd3:             w = 16'sh0100;
            default:          w = '0;
        endcase
        return w;
    endfunction

    // Floor shift back to Q8.8, optional ReLU, then clamp to the 16-bit range.
    function automatic logic signed [15:0] finalize(input logic signed [39:0] a, input logic relu);
        logic signed [39:0] s;
        logic signed [15:0] r;
        s = a >>> FRAC;
        if (relu && s < 0)            r = '0;
        else if (s > 40'sd32767)      r = 16'sh7FFF;
        else if (s < -40'sd32768)     r = 16'sh8000;
        else                          r = s[15:0];
        return r;
    endfunction

    always_comb begin
        mac_a = '0;
        mac_b = '0;
        if (state_q == S_L1) begin
            for (int i = 0; i < 6; i++)
                if (tap_q == 3'(i)) mac_a = xbuf_q[i];
            mac_b = w1_rom(nrn_q, tap_q);
        end else if (state_q == S_L2) begin
            for (int i = 0; i < 4; i++)
                if (tap_q == 3'(i)) mac_a = h_q[i];
            mac_b = w2_rom(tap_q);
        end
    end

    assign prod    = mac_a * mac_b;
    assign fin_val = finalize(acc_q, state_q == S_L1);

    always_comb begin
        state_d = state_q;
        nrn_d   = nrn_q;
        tap_d   = tap_q;
        acc_d   = acc_q;
        out_d   = out_q;
        vld_d   = vld_q;
        load_en = 1'b0;
        h_we    = 1'b0;
        case (state_q)
            S_LOAD: begin
                load_en = 1'b1;
                acc_d   = ACC_PRELOAD;
                nrn_d   = '0;
                tap_d   = '0;
                state_d = S_L1;
            end
            S_L1: begin
                if (tap_q == 3'd6) begin
                    h_we  = 1'b1;
                    acc_d = ACC_PRELOAD;
                    tap_d = '0;
                    nrn_d = nrn_q + 2'd1;
                    if (nrn_q == 2'd3) state_d = S_L2;
                end else begin
                    acc_d = acc_q + 40'(prod);
                    tap_d = tap_q + 3'd1;
                end
            end
            S_L2: begin
                if (tap_q == 3'd4) begin
                    out_d   = fin_val;
                    vld_d   = 1'b1;
                    acc_d   = ACC_PRELOAD;
                    tap_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    acc_d = acc_q + 40'(prod);
                    tap_d = tap_q + 3'd1;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            nrn_q   <= '0;
            tap_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nrn_q   <= nrn_d;
            tap_q   <= tap_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) xbuf_q[i] <= '0;
            for (int i = 0; i < 4; i++) h_q[i] <= '0;
        end else begin
            if (load_en)
                for (int i = 0; i < 6; i++) xbuf_q[i] <= data_in[i];
            if (h_we) h_q[nrn_q] <= fin_val;
        end
    end

    assign data_out   = out_q;
    assign data_out_v = vld_q;

endmodule

// File: tb/tb_nn_top.sv
// Bench for nn_top: vector table fed through a result queue, cycle-exact latency/stability checks,
// plus an asynchronous mid-inference reset sequence.
module tb_nn_top;

    typedef struct packed {
        logic [5:0][15:0] x;
        logic [15:0]      y;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] data_in [6];
    logic [15:0] data_out;
    logic        data_out_v;

    vec_t        vecs [8];
    logic [15:0] sb [$];
    int          n_chk  = 0;
    int          n_pass = 0;

    nn_top #(.FRAC(8)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_out_v (data_out_v)
    );

    always #5 clk_in = ~clk_in;

    function automatic vec_t mk(input logic [15:0] a0, a1, a2, a3, a4, a5, input logic [15:0] y);
        vec_t v;
        v.x[0] = a0; v.x[1] = a1; v.x[2] = a2;
        v.x[3] = a3; v.x[4] = a4; v.x[5] = a5;
        v.y    = y;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input int idx);
        for (int i = 0; i < 6; i++) data_in[i] = vecs[idx].x[i];
        sb.push_back(vecs[idx].y);
    endtask

    // Called at a negedge with reset held low: releases reset and checks every edge
    // until nvec results have come out, changing inputs 5 cycles after each LOAD.
    task automatic run_seq(input int first_vec, input int nvec);
        int          e;
        logic [15:0] last;
        logic [15:0] exp;
        e    = 0;
        last = '0;
        drive(first_vec);
        rst_n = 1'b1;
        while (e < 34 * nvec) begin
            @(posedge clk_in);
            e++;
            @(negedge clk_in);
            if (e % 34 == 0) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 16'h0001, 16'h0000);
                    exp = last;
                end else begin
                    exp = sb.pop_front();
                end
                chk("result", data_out, exp);
                chk("valid_at_result", {15'd0, data_out_v}, 16'd1);
                last = exp;
            end else begin
                chk("out_stable", data_out, last);
                chk("valid_level", {15'd0, data_out_v}, {15'd0, (e > 34)});
            end
            if (e % 34 == 6 && (e / 34) < nvec - 1) drive(first_vec + e / 34 + 1);
        end
    endtask

    initial begin
        vecs[0] = mk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0300);
        vecs[1] = mk(16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0300);
        vecs[2] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0080);
        vecs[3] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000);
        vecs[4] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        // h = {1.75, 2.0, 0.1875, 1.375}; y = 0.5*3.9375 + 1.375 = 3.34375
        vecs[5] = mk(16'h0180, 16'h0040, 16'hFF00, 16'h0300, 16'h0010, 16'h0020, 16'h0358);
        // Truncation: 1.5 LSB floors to 1, 0.5 LSB floors to 0.
        vecs[6] = mk(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001);
        vecs[7] = mk(16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        for (int i = 0; i < 6; i++) data_in[i] = 16'h0100;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("reset_out", data_out, 16'h0000);
        chk("reset_valid", {15'd0, data_out_v}, 16'd0);

        run_seq(0, 8);

        // Mid-inference reset: fresh run, then reset during L1 of the second inference.
        @(negedge clk_in);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk_in);
        run_seq(1, 1);
        repeat (6) begin
            @(posedge clk_in);
            @(negedge clk_in);
        end
        chk("pre_abort_valid", {15'd0, data_out_v}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", data_out, 16'h0000);
        chk("async_reset_valid", {15'd0, data_out_v}, 16'd0);
        sb.delete();
        repeat (2) @(negedge clk_in);
        chk("held_reset_valid", {15'd0, data_out_v}, 16'd0);
        run_seq(2, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
